// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame generator: default 640x480@60 timing,
// the 24-bit colour type and the eight colour-bar constants.
package vga_pkg;

  localparam int DEF_DIV    = 2;
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_CW     = 10;
  localparam int DEF_BOX_W  = 32;
  localparam int DEF_BOX_H  = 32;

  typedef logic [23:0] color_t;

  // Bar k lights R/G/B from bits 2/1/0 of k
  localparam color_t BAR_0 = 24'h000000;
  localparam color_t BAR_1 = 24'h0000FF;
  localparam color_t BAR_2 = 24'h00FF00;
  localparam color_t BAR_3 = 24'h00FFFF;
  localparam color_t BAR_4 = 24'hFF0000;
  localparam color_t BAR_5 = 24'hFF00FF;
  localparam color_t BAR_6 = 24'hFFFF00;
  localparam color_t BAR_7 = 24'hFFFFFF;

  function automatic color_t bar_color(input logic [2:0] k);
    color_t c;
    case (k)
      3'd0:    c = BAR_0;
      3'd1:    c = BAR_1;
      3'd2:    c = BAR_2;
      3'd3:    c = BAR_3;
      3'd4:    c = BAR_4;
      3'd5:    c = BAR_5;
      3'd6:    c = BAR_6;
      3'd7:    c = BAR_7;
      default: c = BAR_0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Clock-enable divider: registered tick, high for one clk every DIV clks.
// The first tick appears DIV-1 clks after reset release.
module vga_tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt_r;
  logic [DW-1:0] cnt_next_s;

  // Next divider count, wrapping at the terminal count
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_r == LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + DW'(1);
    end
  end

  // Divider state and registered tick (tick marks the terminal-count cycle)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      tick  <= (cnt_r == LAST);
    end
  end

endmodule

// File: rtl/vga_frame_gen.sv
// Parametrised VGA frame generator: pixel tick, h/v timing, box over
// background with frame-synchronous shadow update, registered outputs.
// Optional feature macro: VGA_TEST_PATTERN_EN (8 colour bars when mode = 1).
module vga_frame_gen
  import vga_pkg::*;
#(
  parameter int   DIV    = DEF_DIV,
  parameter int   H_VIS  = DEF_H_VIS,
  parameter int   H_FP   = DEF_H_FP,
  parameter int   H_SYNC = DEF_H_SYNC,
  parameter int   H_BP   = DEF_H_BP,
  parameter int   V_VIS  = DEF_V_VIS,
  parameter int   V_FP   = DEF_V_FP,
  parameter int   V_SYNC = DEF_V_SYNC,
  parameter int   V_BP   = DEF_V_BP,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0,
  parameter int   CW     = DEF_CW,
  parameter int   BOX_W  = DEF_BOX_W,
  parameter int   BOX_H  = DEF_BOX_H
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] box_x,
  input  logic [CW-1:0] box_y,
  input  logic [23:0]   color_fg,
  input  logic [23:0]   color_bg,
  input  logic          mode,
  output logic          hSync,
  output logic          vSync,
  output logic          bright,
  output logic          countEn,
  output logic [23:0]   rgb,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          frameStart
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int WW      = CW + 1;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [WW-1:0] H_VIS_W    = WW'(H_VIS);
  localparam logic [WW-1:0] V_VIS_W    = WW'(V_VIS);
  localparam logic [WW-1:0] HS_START_W = WW'(H_VIS + H_FP);
  localparam logic [WW-1:0] HS_END_W   = WW'(H_VIS + H_FP + H_SYNC);
  localparam logic [WW-1:0] VS_START_W = WW'(V_VIS + V_FP);
  localparam logic [WW-1:0] VS_END_W   = WW'(V_VIS + V_FP + V_SYNC);
  localparam logic [WW-1:0] BOX_W_W    = WW'(BOX_W);
  localparam logic [WW-1:0] BOX_H_W    = WW'(BOX_H);

  logic [CW-1:0] h_r, v_r, h_next_s, v_next_s;
  logic [WW-1:0] h_w_s, v_w_s;
  logic          frame_end_s;
  logic [CW-1:0] sh_box_x_r, sh_box_y_r;
  color_t        sh_fg_r, sh_bg_r;
  logic          bright_s, hs_act_s, vs_act_s, in_box_s;
  color_t        pix_s;

  vga_tick_div #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (countEn)
  );

  // Widened coordinates so box/sync compares never wrap
  assign h_w_s = {1'b0, h_r};
  assign v_w_s = {1'b0, v_r};

  // Next raster position; the last tick of the frame also flags the shadow load
  always_comb begin
    h_next_s    = h_r;
    v_next_s    = v_r;
    frame_end_s = 1'b0;
    if (countEn) begin
      if (h_r == H_LAST) begin
        h_next_s = '0;
        if (v_r == V_LAST) begin
          v_next_s    = '0;
          frame_end_s = 1'b1;
        end else begin
          v_next_s = v_r + CW'(1);
        end
      end else begin
        h_next_s = h_r + CW'(1);
      end
    end else begin
      h_next_s = h_r;
    end
  end

  // Raster counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_r <= '0;
      v_r <= '0;
    end else begin
      h_r <= h_next_s;
      v_r <= v_next_s;
    end
  end

  // Shadow copies of the drawing inputs, refreshed only at frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_box_x_r <= '0;
      sh_box_y_r <= '0;
      sh_fg_r    <= 24'h000000;
      sh_bg_r    <= 24'h000000;
    end else if (frame_end_s) begin
      sh_box_x_r <= box_x;
      sh_box_y_r <= box_y;
      sh_fg_r    <= color_fg;
      sh_bg_r    <= color_bg;
    end else begin
      sh_box_x_r <= sh_box_x_r;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_VIS / 8;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

  logic           sh_mode_r;
  logic [BPW-1:0] bar_px_r;
  logic [2:0]     bar_idx_r;

  // Shadow copy of the mode select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_mode_r <= 1'b0;
    end else if (frame_end_s) begin
      sh_mode_r <= mode;
    end else begin
      sh_mode_r <= sh_mode_r;
    end
  end

  // Bar counter: steps every BAR_W visible pixels, cleared for the next h = 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bar_px_r  <= '0;
      bar_idx_r <= 3'd0;
    end else if (countEn) begin
      if (h_r == H_LAST) begin
        bar_px_r  <= '0;
        bar_idx_r <= 3'd0;
      end else if (h_w_s < H_VIS_W) begin
        if (bar_px_r == BAR_LAST) begin
          bar_px_r  <= '0;
          bar_idx_r <= bar_idx_r + 3'd1;
        end else begin
          bar_px_r  <= bar_px_r + BPW'(1);
        end
      end else begin
        bar_px_r <= bar_px_r;
      end
    end else begin
      bar_px_r <= bar_px_r;
    end
  end
`else
  logic unused_mode_s;
  assign unused_mode_s = mode;
`endif

  // Decode the current position into sync, visibility and pixel colour
  always_comb begin
    bright_s = (h_w_s < H_VIS_W) && (v_w_s < V_VIS_W);
    hs_act_s = (h_w_s >= HS_START_W) && (h_w_s < HS_END_W);
    vs_act_s = (v_w_s >= VS_START_W) && (v_w_s < VS_END_W);
    in_box_s = (h_w_s >= {1'b0, sh_box_x_r}) && (h_w_s < ({1'b0, sh_box_x_r} + BOX_W_W)) &&
               (v_w_s >= {1'b0, sh_box_y_r}) && (v_w_s < ({1'b0, sh_box_y_r} + BOX_H_W));
    pix_s    = 24'h000000;
    if (!bright_s) begin
      pix_s = 24'h000000;
`ifdef VGA_TEST_PATTERN_EN
    end else if (sh_mode_r) begin
      pix_s = bar_color(bar_idx_r);
`endif
    end else if (in_box_s) begin
      pix_s = sh_fg_r;
    end else begin
      pix_s = sh_bg_r;
    end
  end

  // Output stage: capture the decode on each tick, so all outputs lag by one pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hSync      <= ~H_POL;
      vSync      <= ~V_POL;
      bright     <= 1'b0;
      rgb        <= 24'h000000;
      hCount     <= '0;
      vCount     <= '0;
      frameStart <= 1'b0;
    end else begin
      frameStart <= countEn && (h_r == '0) && (v_r == '0);
      if (countEn) begin
        hSync  <= hs_act_s ? H_POL : ~H_POL;
        vSync  <= vs_act_s ? V_POL : ~V_POL;
        bright <= bright_s;
        rgb    <= pix_s;
        hCount <= h_r;
        vCount <= v_r;
      end else begin
        rgb <= rgb;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_gen.sv
// Self-checking bench for vga_frame_gen (H 8/2/2/2, V 4/1/1/1, DIV 2, box 2x2).
module tb_vga_frame_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  box_x = 4'd0, box_y = 4'd0;
  logic [23:0] color_fg = 24'h0, color_bg = 24'h0;
  logic        mode = 1'b0;
  logic        hSync, vSync, bright, countEn, frameStart;
  logic [23:0] rgb;
  logic [3:0]  hCount, vCount;

  always #5 clk = ~clk;

  vga_frame_gen #(
    .DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(4), .BOX_W(2), .BOX_H(2)
  ) dut (
    .clk(clk), .rst(rst), .box_x(box_x), .box_y(box_y),
    .color_fg(color_fg), .color_bg(color_bg), .mode(mode),
    .hSync(hSync), .vSync(vSync), .bright(bright), .countEn(countEn),
    .rgb(rgb), .hCount(hCount), .vCount(vCount), .frameStart(frameStart)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic        d2_hs, d2_vs, d2_br, d2_ce, d2_fs;
  logic [23:0] d2_rgb;
  logic [4:0]  d2_hc, d2_vc;
  vga_frame_gen #(
    .DIV(2), .H_VIS(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(5), .BOX_W(2), .BOX_H(2)
  ) dut_tp (
    .clk(clk), .rst(rst), .box_x(5'd0), .box_y(5'd0),
    .color_fg(24'h0), .color_bg(24'h0), .mode(1'b1),
    .hSync(d2_hs), .vSync(d2_vs), .bright(d2_br), .countEn(d2_ce),
    .rgb(d2_rgb), .hCount(d2_hc), .vCount(d2_vc), .frameStart(d2_fs)
  );
`endif

  typedef struct {
    logic [3:0]  bx, by;
    logic [23:0] fg, bg;
    logic [3:0]  ph, pv;
    logic [23:0] exp_rgb;
  } vec_t;

  localparam int NV = 15;
  vec_t        vecs [NV];
  logic [23:0] sb [$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (frameStart) begin seen = 1'b1; break; end
    end
    if (!seen) check({name, "_frame_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input string name, input logic [3:0] ph, input logic [3:0] pv);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (hCount == ph && vCount == pv) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) check({name, "_pos_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic probe(input string name, input logic [3:0] ph, input logic [3:0] pv);
    logic [23:0] e;
    wait_pos(name, ph, pv);
    e = sb.pop_front();
    check(name, {8'h0, rgb}, {8'h0, e});
  endtask

  // Enters with rst low; checks reset values, release timing, frame period and line timing.
  task automatic power_up_seq(input string tag);
    int n, errs, hs_lo, vs_lo, br_hi;
    @(negedge clk);
    check({tag, "_rst_outs"}, {hSync, vSync, bright, countEn, frameStart, rgb},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
    check({tag, "_rst_cnt"}, {hCount, vCount}, 8'h00);
    rst = 1'b1;
    @(negedge clk);                      // after edge 0
    check({tag, "_c0"}, {countEn, hSync, vSync, frameStart, rgb}, {1'b0, 1'b1, 1'b1, 1'b0, 24'h0});
    @(negedge clk);                      // after edge 1: first tick cycle
    check({tag, "_c1"}, {countEn, hSync, frameStart, bright, rgb}, {1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
    @(negedge clk);                      // after edge 2: pixel (0,0) presented
    check({tag, "_c2"}, {countEn, frameStart, bright, hCount, vCount, rgb},
          {1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 24'h0});
    @(negedge clk);                      // after edge 3
    check({tag, "_c3"}, {countEn, frameStart}, {1'b1, 1'b0});
    n = 1;                               // one clk already elapsed since the frameStart edge
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (frameStart) break;
    end
    check({tag, "_frame_period"}, n, 196);
    errs = 0; hs_lo = 0; vs_lo = 0; br_hi = 0;
    for (int i = 0; i < 196; i++) begin
      @(negedge clk);
      if (hSync !== !(int'(hCount) >= 10 && int'(hCount) <= 11)) errs++;
      if (vSync !== !(int'(vCount) == 5)) errs++;
      if (bright !== (int'(hCount) < 8 && int'(vCount) < 4)) errs++;
      if (!bright && rgb !== 24'h0) errs++;
      if (int'(hCount) > 13 || int'(vCount) > 6) errs++;
      if (!hSync) hs_lo++;
      if (!vSync) vs_lo++;
      if (bright) br_hi++;
    end
    check({tag, "_line_errs"}, errs, 0);
    check({tag, "_hsync_clks"}, hs_lo, 28);
    check({tag, "_vsync_clks"}, vs_lo, 28);
    check({tag, "_bright_clks"}, br_hi, 64);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit changed;
    bit seen;
    vecs[0]  = '{4'd3, 4'd1, 24'hFF0000, 24'h0000FF, 4'd3, 4'd1, 24'hFF0000};
    vecs[1]  = '{4'd3, 4'd1, 24'hFF0000, 24'h0000FF, 4'd4, 4'd2, 24'hFF0000};
    vecs[2]  = '{4'd3, 4'd1, 24'hFF0000, 24'h0000FF, 4'd2, 4'd1, 24'h0000FF};
    vecs[3]  = '{4'd3, 4'd1, 24'hFF0000, 24'h0000FF, 4'd5, 4'd2, 24'h0000FF};
    vecs[4]  = '{4'd3, 4'd1, 24'hFF0000, 24'h0000FF, 4'd3, 4'd3, 24'h0000FF};
    vecs[5]  = '{4'd3, 4'd1, 24'hFF0000, 24'h0000FF, 4'd9, 4'd1, 24'h000000};
    vecs[6]  = '{4'd3, 4'd1, 24'hFF0000, 24'h0000FF, 4'd3, 4'd5, 24'h000000};
    vecs[7]  = '{4'd7, 4'd1, 24'hFF0000, 24'h0000FF, 4'd7, 4'd1, 24'hFF0000};
    vecs[8]  = '{4'd7, 4'd1, 24'hFF0000, 24'h0000FF, 4'd0, 4'd1, 24'h0000FF};
    vecs[9]  = '{4'd7, 4'd1, 24'hFF0000, 24'h0000FF, 4'd7, 4'd2, 24'hFF0000};
    vecs[10] = '{4'd0, 4'd3, 24'h00FF00, 24'h123456, 4'd0, 4'd3, 24'h00FF00};
    vecs[11] = '{4'd0, 4'd3, 24'h00FF00, 24'h123456, 4'd1, 4'd3, 24'h00FF00};
    vecs[12] = '{4'd0, 4'd3, 24'h00FF00, 24'h123456, 4'd2, 4'd3, 24'h123456};
    vecs[13] = '{4'd0, 4'd3, 24'h00FF00, 24'h123456, 4'd0, 4'd2, 24'h123456};
    vecs[14] = '{4'd0, 4'd3, 24'h00FF00, 24'h123456, 4'd1, 4'd4, 24'h000000};

    power_up_seq("pwr");

    // Table-driven box/clip vectors; new settings take effect two frame starts later
    for (int i = 0; i < NV; i++) begin
      changed = (i == 0) || vecs[i].bx != box_x || vecs[i].by != box_y ||
                vecs[i].fg != color_fg || vecs[i].bg != color_bg;
      box_x = vecs[i].bx; box_y = vecs[i].by;
      color_fg = vecs[i].fg; color_bg = vecs[i].bg;
      sb.push_back(vecs[i].exp_rgb);
      if (changed) begin
        wait_frame($sformatf("vec%0d_a", i));
        wait_frame($sformatf("vec%0d_b", i));
      end
      probe($sformatf("vec%0d", i), vecs[i].ph, vecs[i].pv);
    end

    // Tear-free update: change box_x mid-frame
    box_x = 4'd3; box_y = 4'd1; color_fg = 24'hFF0000; color_bg = 24'h0000FF;
    wait_frame("tear_a");
    wait_frame("tear_b");
    wait_pos("tear_mid", 4'd1, 4'd2);
    box_x = 4'd5;
    sb.push_back(24'hFF0000); probe("tear_same_x3", 4'd3, 4'd2);
    sb.push_back(24'h0000FF); probe("tear_same_x5", 4'd5, 4'd2);
    wait_frame("tear_next");
    sb.push_back(24'h0000FF); probe("tear_next_x3", 4'd3, 4'd1);
    sb.push_back(24'hFF0000); probe("tear_next_x5", 4'd5, 4'd1);
    sb.push_back(24'hFF0000); probe("tear_next_x6", 4'd6, 4'd2);

`ifdef VGA_TEST_PATTERN_EN
    begin
      logic [23:0] bar_exp [8];
      logic [23:0] e;
      bar_exp = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                  24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
      for (int f = 0; f < 2; f++) begin
        seen = 1'b0;
        for (int i = 0; i < 800; i++) begin
          @(negedge clk);
          if (d2_fs) begin seen = 1'b1; break; end
        end
        check("tp_frame_seen", seen, 1'b1);
      end
      for (int k = 0; k < 16; k++) begin
        sb.push_back(bar_exp[k / 2]);
        check($sformatf("tp_hc%0d", k), d2_hc, k);
        e = sb.pop_front();
        check($sformatf("tp_rgb%0d", k), {8'h0, d2_rgb}, {8'h0, e});
        @(negedge clk);
        @(negedge clk);
      end
    end
`endif

    // Mid-frame reset during vSync
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vSync == 1'b0) begin seen = 1'b1; break; end
    end
    check("vsync_seen", seen, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_outs", {hSync, vSync, bright, countEn, frameStart, rgb},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
    check("async_rst_cnt", {hCount, vCount}, 8'h00);
    power_up_seq("mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
